// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative divider.
// State codes, handshake levels and the double-width result bus.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    typedef logic [63:0] double_reg_bus_t;

endpackage

// File: rtl/div_unit_step.sv
// One restoring division step: trial subtract, keep or restore.
// The partial remainder is always below twice the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic             neg;
    logic [WIDTH-1:0] diff;

    // A non-negative difference is below the divisor, so WIDTH bits hold it.
    assign neg   = rem_i < {1'b0, div_i};
    assign diff  = rem_i[WIDTH-1:0] - div_i;
    assign rem_o = neg ? rem_i[WIDTH-1:0] : diff;
    assign q_o   = ~neg;

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU in the EX stage.
// Result {remainder, quotient} is held until EX drops start_i.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam int CW = $clog2(WIDTH);

    div_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic               sign1_q, sign1_d;
    logic               sign2_q, sign2_d;
    logic               signed_q, signed_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH-1:0]   op1_abs;
    logic [WIDTH-1:0]   op2_abs;
    logic [WIDTH-1:0]   step_rem;
    logic               step_q;
    logic [WIDTH-1:0]   quot_raw;
    logic [WIDTH-1:0]   rem_raw;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign op1_abs = (signed_i && opdata1_i[WIDTH-1]) ?
                     (~opdata1_i + 1'b1) : opdata1_i;
    assign op2_abs = (signed_i && opdata2_i[WIDTH-1]) ?
                     (~opdata2_i + 1'b1) : opdata2_i;

    // work_q = {partial remainder, unconsumed dividend / quotient bits}
    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i (work_q[2*WIDTH-1:WIDTH-1]),
        .div_i (div_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    assign quot_raw = work_q[WIDTH-1:0];
    assign rem_raw  = work_q[2*WIDTH-1:WIDTH];
    assign quot_fix = (signed_q && (sign1_q ^ sign2_q)) ?
                      (~quot_raw + 1'b1) : quot_raw;
    assign rem_fix  = (signed_q && sign1_q) ?
                      (~rem_raw + 1'b1) : rem_raw;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        div_d    = div_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        signed_d = signed_q;
        result_d = result_q;
        ready_d  = ready_q;
        unique case (state_q)
            DIV_FREE: begin
                if (start_i == DIV_START && !annul_i) begin
                    sign1_d  = opdata1_i[WIDTH-1];
                    sign2_d  = opdata2_i[WIDTH-1];
                    signed_d = signed_i;
                    cnt_d    = '0;
                    if (opdata2_i == '0) begin
                        state_d = DIV_BYZERO;
                        work_d  = '0;
                    end else begin
                        state_d = DIV_ON;
                        work_d  = {{WIDTH{1'b0}}, op1_abs};
                        div_d   = op2_abs;
                    end
                end
            end
            DIV_BYZERO: begin
                work_d = '0;
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    state_d = DIV_END;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    work_d = {step_rem, work_q[WIDTH-2:0], step_q};
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = DIV_END;
                    end
                end
            end
            DIV_END: begin
                // First END cycle applies the sign fixup; later ones hold.
                if (ready_q == DIV_RESULT_NOT_READY) begin
                    result_d = {rem_fix, quot_fix};
                    ready_d  = DIV_RESULT_READY;
                end else if (start_i == DIV_STOP) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end
            end
            default: begin
                state_d = DIV_FREE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= '0;
            work_q   <= '0;
            div_q    <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            signed_q <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            div_q    <= div_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            signed_q <= signed_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = start_i & ~ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed vector bench for div_unit: results, latency, handshake,
// annul and asynchronous reset behaviour.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int tests;
    int fails;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .annul_i   (annul_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one division, wait for ready, then release start.
    task automatic run_div(input string name, input logic s,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int exp_lat);
        int lat;
        lat = -1;
        @(negedge clk);
        start_i   = 1'b1;
        signed_i  = s;
        opdata1_i = a;
        opdata2_i = b;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                check({name, " busy"}, {63'd0, busy_o}, 64'd1);
                opdata1_i = $urandom;
                opdata2_i = $urandom;
                signed_i  = ~s;
            end
            if (ready_o) begin
                lat = k - 1;
                break;
            end
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, result_o, exp);
        check({name, " busy_done"}, {63'd0, busy_o}, 64'd0);
        @(posedge clk);
        #1;
        check({name, " hold"}, result_o, exp);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, " ready_drop"}, {63'd0, ready_o}, 64'd0);
        check({name, " result_clr"}, result_o, 64'd0);
    endtask

    initial begin
        int seen;
        tests = 0;
        fails = 0;

        vecs[0]  = '{1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,
                     {32'hFFFFFFFF, 32'hFFFFFFFD}, 33};
        vecs[2]  = '{1'b1, 32'd7, 32'hFFFFFFFE,
                     {32'd1, 32'hFFFFFFFD}, 33};
        vecs[3]  = '{1'b0, 32'd5, 32'd0, 64'd0, 2};
        vecs[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF,
                     {32'd0, 32'h80000000}, 33};
        vecs[5]  = '{1'b0, 32'hFFFFFFFF, 32'd1,
                     {32'd0, 32'hFFFFFFFF}, 33};
        vecs[6]  = '{1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33};
        vecs[7]  = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,
                     {32'hFFFFFFFE, 32'd14}, 33};
        vecs[8]  = '{1'b0, 32'd3, 32'd10, {32'd3, 32'd0}, 33};
        vecs[9]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF,
                     {32'h80000000, 32'd0}, 33};
        vecs[10] = '{1'b1, 32'd5, 32'd0, 64'd0, 2};
        vecs[11] = '{1'b1, 32'd0, 32'd5, 64'd0, 33};
        vecs[12] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     {32'd0, 32'd1}, 33};

        rst       = 1'b1;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        annul_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset result", result_o, 64'd0);
        check("reset ready", {63'd0, ready_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Operands present without start: nothing happens.
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        repeat (3) @(posedge clk);
        #1;
        check("idle ready", {63'd0, ready_o}, 64'd0);
        check("idle result", result_o, 64'd0);

        for (int i = 0; i < 13; i++) begin
            run_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a,
                    vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // Annul on ON cycle 10 of 100/7.
        @(negedge clk);
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (ready_o) seen++;
        end
        check("annul no_ready", 64'(seen), 64'd0);
        check("annul result", result_o, 64'd0);
        run_div("post_annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        // Async reset between edges while ON.
        @(negedge clk);
        start_i   = 1'b1;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_on ready", {63'd0, ready_o}, 64'd0);
        check("rst_on result", result_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Async reset between edges while a result is presented.
        @(negedge clk);
        start_i   = 1'b1;
        opdata1_i = 32'd20;
        opdata2_i = 32'd6;
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                seen = 1;
                break;
            end
        end
        check("rst_end reached", 64'(seen), 64'd1);
        check("rst_end pre", result_o, {32'd2, 32'd3});
        #2;
        rst = 1'b1;
        #1;
        check("rst_end ready", {63'd0, ready_o}, 64'd0);
        check("rst_end result", result_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        run_div("post_rst", 1'b0, 32'd9, 32'd4, {32'd1, 32'd2}, 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
